// File: rtl/mips_dbg_pkg.sv
// Shared constants and types for the MIPS debug/loader path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_dbg_pkg;

  // Command bytes recognised on the UART debug channel
  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'

  // Terminator instruction: stored like any other word, and it ends a load
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles a stream of bytes into little-endian NBITS words (first byte -> [7:0]).
// Latency: word_vld is a one-cycle pulse the cycle after the last byte of a word is accepted.
// Backpressure: none; every byte_vld is taken, clear drops any partial word.
module byte_to_word_packer #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_vld,
  input  logic [7:0]       byte_dat,
  output logic             word_vld,
  output logic [NBITS-1:0] word_dat
);

  localparam int NBYTES = NBITS / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NBYTES - 1);

  logic [CW-1:0]    lane_cnt;
  logic [NBITS-1:0] asm_q;

  // Shift each byte in from the top so the earliest byte ends up in the low lane
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt <= '0;
      asm_q    <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        lane_cnt <= '0;
        asm_q    <= '0;
      end else if (byte_vld) begin
        asm_q <= {byte_dat, asm_q[NBITS-1:8]};
        if (lane_cnt == LAST_LANE) begin
          lane_cnt <= '0;
          word_vld <= 1'b1;
          word_dat <= {byte_dat, asm_q[NBITS-1:8]};
        end else begin
          lane_cnt <= lane_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: fills instruction memory and gates core reset/clock-enable (optional LOADER_CHECKSUM_EN).
// Latency: memory write appears two cycles after the 4th byte of a word; control outputs one cycle after a command.
// Backpressure: none; bytes may arrive every cycle, including during a memory-write cycle.
module uart_program_loader
  import mips_dbg_pkg::*;
#(
  parameter int               NBITS      = 32,
  parameter int               IMEM_ABITS = 6,
  parameter logic [NBITS-1:0] HALT_WORD  = NBITS'(HALT_WORD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_cpu_halt,
  output logic                  o_imem_we,
  output logic [IMEM_ABITS-1:0] o_imem_addr,
  output logic [NBITS-1:0]      o_imem_data,
  output logic                  o_cpu_reset,
  output logic                  o_cpu_en,
  output logic                  o_load_done,
  output logic                  o_err
);

  localparam logic [IMEM_ABITS-1:0] LAST_ADDR = '1;

  loader_state_t         state;
  logic [IMEM_ABITS-1:0] addr;
  logic                  pk_clear;
  logic                  pk_vld;
  logic                  word_vld;
  logic [NBITS-1:0]      word_dat;
  logic                  word_is_halt;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       ck_wait;
  logic       ck_byte;
`endif

  // Route bytes: an 'L' in IDLE restarts the packer, LOAD bytes feed it
  always_comb begin
    pk_clear     = 1'b0;
    pk_vld       = 1'b0;
    word_is_halt = word_vld && (word_dat == HALT_WORD);
`ifdef LOADER_CHECKSUM_EN
    // The byte following the halt word is the checksum, even if it lands on the write cycle
    ck_byte = i_rx_valid && (state == ST_LOAD) && (ck_wait || word_is_halt);
`endif
    if (state == ST_IDLE && i_rx_valid && i_rx_data == CMD_LOAD) begin
      pk_clear = 1'b1;
    end
    if (state == ST_LOAD && i_rx_valid) begin
      pk_vld = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (ck_wait || word_is_halt) begin
        pk_vld = 1'b0;
      end
`endif
    end
  end

  byte_to_word_packer #(
    .NBITS(NBITS)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .byte_vld (pk_vld),
    .byte_dat (i_rx_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every load byte, plus the flag that the halt word has been written
  always_ff @(posedge clk) begin
    if (reset || pk_clear) begin
      csum    <= '0;
      ck_wait <= 1'b0;
    end else begin
      if (pk_vld) begin
        csum <= csum ^ i_rx_data;
      end
      if (ck_byte) begin
        ck_wait <= 1'b0;
      end else if (state == ST_LOAD && word_is_halt) begin
        ck_wait <= 1'b1;
      end
    end
  end
`endif

  // Loader FSM with registered memory-write and core-control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_cpu_reset <= 1'b1;
      o_cpu_en    <= 1'b0;
      o_load_done <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_imem_we   <= 1'b0;
      o_load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_cpu_en <= 1'b0;
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state       <= ST_LOAD;
                o_cpu_reset <= 1'b1;
                addr        <= '0;
              end
              CMD_RUN: begin
                state       <= ST_RUN;
                o_cpu_reset <= 1'b0;
                o_cpu_en    <= 1'b1;
              end
              CMD_STEP: begin
                o_cpu_reset <= 1'b0;
                o_cpu_en    <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_LOAD: begin
          o_cpu_en <= 1'b0;
          if (word_vld) begin
            o_imem_we   <= 1'b1;
            o_imem_addr <= addr;
            o_imem_data <= word_dat;
            addr        <= addr + IMEM_ABITS'(1);
            if (word_is_halt) begin
`ifndef LOADER_CHECKSUM_EN
              o_load_done <= 1'b1;
              o_cpu_reset <= 1'b0;
              state       <= ST_IDLE;
`endif
            end else if (addr == LAST_ADDR) begin
              // Memory is full and no terminator arrived: refuse to wrap
              state       <= ST_ERROR;
              o_err       <= 1'b1;
              o_cpu_reset <= 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          if (ck_byte) begin
            if (i_rx_data == csum) begin
              o_load_done <= 1'b1;
              o_cpu_reset <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              state       <= ST_ERROR;
              o_err       <= 1'b1;
              o_cpu_reset <= 1'b1;
            end
          end
`endif
        end

        ST_RUN: begin
          o_cpu_en <= 1'b1;
          if (i_cpu_halt || (i_rx_valid && i_rx_data == CMD_PAUSE)) begin
            state    <= ST_IDLE;
            o_cpu_en <= 1'b0;
          end
        end

        ST_ERROR: begin
          o_err       <= 1'b1;
          o_cpu_reset <= 1'b1;
          o_cpu_en    <= 1'b0;
          if (i_rx_valid && i_rx_data == CMD_CLEAR) begin
            state <= ST_IDLE;
            o_err <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader (checksum steps only when LOADER_CHECKSUM_EN is defined).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_program_loader;
  import mips_dbg_pkg::*;

  localparam int          AB    = 6;
  localparam int          DEPTH = 1 << AB;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          cpu_halt;
  logic          imem_we;
  logic [AB-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          cpu_reset;
  logic          cpu_en;
  logic          load_done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_program_loader #(.NBITS(32), .IMEM_ABITS(AB)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_cpu_halt  (cpu_halt),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_data (imem_data),
    .o_cpu_reset (cpu_reset),
    .o_cpu_en    (cpu_en),
    .o_load_done (load_done),
    .o_err       (err)
  );

  // Observed activity, sampled just after each rising edge
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_done_q[$];
  int          wr_rst_q[$];
  int          done_pulses = 0;
  int          en_cycles   = 0;
  int          en_rises    = 0;
  logic        en_prev     = 1'b0;

  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_data);
      wr_done_q.push_back(int'(load_done));
      wr_rst_q.push_back(int'(cpu_reset));
    end
    if (load_done === 1'b1) done_pulses++;
    if (cpu_en === 1'b1) en_cycles++;
    if (cpu_en === 1'b1 && en_prev !== 1'b1) en_rises++;
    en_prev = cpu_en;
  end

  // Words of the current load, as the host would send them
  logic [31:0] ld_words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_done_q.delete();
    wr_rst_q.delete();
    done_pulses = 0;
    en_cycles   = 0;
    en_rises    = 0;
  endtask

  // Present one byte for exactly one rising edge, then stay quiet for gap cycles
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    cpu_halt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  function automatic logic [7:0] rnd_gap_byte(input logic [7:0] avoid);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == avoid) b = b + 8'd1;
    return b;
  endfunction

  // Send 'L', all words little-endian, then (if enabled) the XOR checksum
  task automatic send_load(input int maxgap);
    logic [7:0] x;
    x = 8'h00;
    send(CMD_LOAD, $urandom_range(0, maxgap));
    foreach (ld_words[i]) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = 8'(ld_words[i] >> (8 * k));
        x = x ^ b;
        send(b, $urandom_range(0, maxgap));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(x, 0);
`endif
    idle(6);
  endtask

  // Reference: word i goes to address i; stop at the terminator or after the last address
  task automatic check_load(input string tag);
    int exp_n;
    bit halted;
    exp_n  = 0;
    halted = 1'b0;
    for (int i = 0; i < ld_words.size(); i++) begin
      exp_n++;
      if (ld_words[i] == HALT) begin
        halted = 1'b1;
        break;
      end
      if (i == DEPTH - 1) break;
    end
    check({tag, "_nwr"}, wr_data_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_data_q.size(); i++) begin
      check($sformatf("%s_a%0d", tag, i), wr_addr_q[i], i);
      check($sformatf("%s_d%0d", tag, i), wr_data_q[i], ld_words[i]);
    end
    if (halted) begin
      check({tag, "_done"}, done_pulses, 1);
      check({tag, "_rst"}, cpu_reset, 1'b0);
      check({tag, "_err"}, err, 1'b0);
`ifndef LOADER_CHECKSUM_EN
      if (wr_done_q.size() > 0) begin
        check({tag, "_done_w"}, wr_done_q[wr_done_q.size()-1], 1);
        check({tag, "_rst_w"}, wr_rst_q[wr_rst_q.size()-1], 0);
      end
`endif
    end else begin
      check({tag, "_done"}, done_pulses, 0);
      check({tag, "_rst"}, cpu_reset, 1'b1);
      check({tag, "_err"}, err, 1'b1);
      check({tag, "_en"}, cpu_en, 1'b0);
    end
  endtask

  initial begin
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cpu_halt = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset values
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_addr, '0);
    check("rst_data", imem_data, 32'h0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_en", cpu_en, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", err, 1'b0);

    // Two-word load from the plan
    clear_mon();
    ld_words = '{32'h0000_0120, HALT};
    send_load(1);
    check_load("ld_basic");

    // Random loads; the first one streams every byte on consecutive cycles
    for (int r = 0; r < 3; r++) begin
      int n;
      clear_mon();
      ld_words.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) ld_words.push_back(rnd_word());
      ld_words.push_back(HALT);
      send_load(r == 0 ? 0 : 2);
      check_load($sformatf("ld_rand%0d", r));
    end

    // Three single steps
    clear_mon();
    for (int i = 0; i < 3; i++) send(CMD_STEP, 2);
    idle(3);
    check("step_cycles", en_cycles, 3);
    check("step_pulses", en_rises, 3);
    check("step_rst", cpu_reset, 1'b0);

    // Bytes with no meaning in IDLE change nothing
    clear_mon();
    send(CMD_PAUSE, 0);
    send(CMD_CLEAR, 0);
    send(8'h00, 2);
    check("idle_ign_en", en_cycles, 0);
    check("idle_ign_wr", wr_data_q.size(), 0);
    check("idle_ign_err", err, 1'b0);

    // Run, ignore noise, then stop on core halt
    send(CMD_RUN, 0);
    check("run_en", cpu_en, 1'b1);
    check("run_rst", cpu_reset, 1'b0);
    for (int i = 0; i < 3; i++) send(rnd_gap_byte(CMD_PAUSE), 1);
    check("run_noise_en", cpu_en, 1'b1);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    check("run_halt_en", cpu_en, 1'b0);
    idle(3);
    check("run_halt_stay", cpu_en, 1'b0);

    // Run, stop on 'P'
    send(CMD_RUN, 2);
    check("run2_en", cpu_en, 1'b1);
    send(CMD_PAUSE, 0);
    check("run_pause_en", cpu_en, 1'b0);

    // Run, 'P' and halt together
    send(CMD_RUN, 2);
    cpu_halt = 1'b1;
    send(CMD_PAUSE, 0);
    cpu_halt = 1'b0;
    check("run_both_en", cpu_en, 1'b0);
    idle(3);
    check("run_both_stay", cpu_en, 1'b0);

    // Overflow: a full memory of non-halt words
    clear_mon();
    ld_words.delete();
    for (int i = 0; i < DEPTH; i++) ld_words.push_back(rnd_word());
    send_load(1);
    check_load("ld_ovf");
    send(CMD_RUN, 2);
    check("err_ign_run_en", cpu_en, 1'b0);
    check("err_ign_run_err", err, 1'b1);
    send(CMD_CLEAR, 0);
    check("err_clr_err", err, 1'b0);
    check("err_clr_rst", cpu_reset, 1'b1);
    idle(2);
    check("err_clr_rst_hold", cpu_reset, 1'b1);

    // Reset in the middle of a word discards it
    clear_mon();
    send(CMD_LOAD, 0);
    send(8'hA5, 0);
    send(8'h5A, 0);
    do_reset();
    idle(3);
    check("rml_nwr_pre", wr_data_q.size(), 0);
    ld_words = '{HALT};
    send_load(0);
    check_load("ld_after_rst");

`ifdef LOADER_CHECKSUM_EN
    // Good checksum
    clear_mon();
    send(CMD_LOAD, 0);
    for (int k = 0; k < 4; k++) send(8'(32'h1122_3344 >> (8 * k)), 0);
    for (int k = 0; k < 4; k++) send(8'hFF, 0);
    send(8'h44, 0);
    check("ck_ok_done", load_done, 1'b1);
    idle(3);
    check("ck_ok_pulses", done_pulses, 1);
    check("ck_ok_rst", cpu_reset, 1'b0);
    check("ck_ok_err", err, 1'b0);

    // Bad checksum
    clear_mon();
    send(CMD_LOAD, 0);
    for (int k = 0; k < 4; k++) send(8'(32'h1122_3344 >> (8 * k)), 0);
    for (int k = 0; k < 4; k++) send(8'hFF, 0);
    send(8'h45, 0);
    idle(3);
    check("ck_bad_err", err, 1'b1);
    check("ck_bad_done", done_pulses, 0);
    check("ck_bad_rst", cpu_reset, 1'b1);
    send(CMD_CLEAR, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
